coin_acceptor: RTL and testbench
================================

Name: coin_acceptor

Overview:
Front-end coin sensing stage that feeds the vending machine FSM's rs1/rs2 coin inputs. Raw mechanical sensor lines for the 1-unit and 2-unit coins bounce and are asynchronous to clk. This block synchronizes and debounces them, classifies each coin, and emits exactly one single-cycle rs1 or rs2 pulse per physical coin. Invalid or refused insertions raise coin_rej, which drives the return chute.

Parameters:
DEB_CYCLES, 4, number of consecutive identical synchronized samples required to accept a code (range 2..255)
CNT_W, 8, width of the accepted-value total (used only with the optional feature)

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  asynchronous, active-low reset
coin1_raw  input  1  raw 1-unit coin sensor, asynchronous, may bounce
coin2_raw  input  1  raw 2-unit coin sensor, asynchronous, may bounce
accept_en  input  1  high = downstream machine can take credit; low = refuse coins (e.g. while dispensing)
rs1  output  1  one-cycle pulse: one 1-unit coin accepted (to vending FSM rs1)
rs2  output  1  one-cycle pulse: one 2-unit coin accepted (to vending FSM rs2)
coin_rej  output  1  one-cycle pulse: coin refused or invalid, route to return chute
total_value  output  CNT_W  running accepted value; zero unless COIN_STATS_EN

Behaviour:
- Reset (rst=0, asynchronous):
  - Synchronizer flops, rs1, rs2, coin_rej, the counters and total_value clear to 0 immediately.
  - State goes to RELEASE, not IDLE, so a coin stuck during reset is never credited.
- Synchronizer: each raw line passes through 2 flops. s = {s2,s1} is the stage-2 output.
- Debounce counter is 8-bit; the release counter is identical in width.
- FSM states and transitions:
  - IDLE: if s != 00, capture sel = s, set cnt = 1, go to DEBOUNCE.
  - DEBOUNCE:
    - s == sel: cnt++. When this edge consumes the DEB_CYCLES-th sample, go to ACCEPT and set the output pulse register.
    - s == 00: glitch; return to IDLE with no output.
    - s nonzero and != sel: restart with sel = s, cnt = 1.
  - ACCEPT, exactly 1 cycle; exactly one output is high:
    - sel=01 and accept_en=1: rs1.
    - sel=10 and accept_en=1: rs2.
    - sel=11 (both sensors) or accept_en=0: coin_rej.
    - accept_en is sampled on the edge that enters ACCEPT.
    - Next state is RELEASE.
  - RELEASE: needs DEB_CYCLES consecutive s==00 samples, then go to IDLE. Any nonzero sample resets the release count to 0. A coin held for any length of time therefore produces only one pulse.
- Outputs are registered; no combinational path from inputs to outputs. rs1, rs2 and coin_rej are mutually exclusive and never high for 2 consecutive cycles.
- Latency: let E0 be the first posedge that samples raw=1 into stage 1, with raw held stable. The pulse is high from after edge E(DEB_CYCLES+1) until edge E(DEB_CYCLES+2). With DEB_CYCLES=4, it is high between E5 and E6.
- Minimum coin-to-coin spacing is 2*DEB_CYCLES+1 cycles of sensor activity plus release time. Faster insertions are merged into the current coin, not double-counted.
- accept_en changing during DEBOUNCE or RELEASE has no effect. Only its value at the ACCEPT entry edge matters.

Optional Feature:
- Macro: COIN_STATS_EN.
- When defined, total_value is a CNT_W-bit register:
  - +1 on each rs1 pulse, +2 on each rs2 pulse; coin_rej does not change it.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Cleared only by reset.
- When not defined, total_value is tied to constant 0 and no counter logic is generated.
- All other behaviour is identical in both builds.

Test Plan:
- Reset with coin1_raw=1 held, then release rst and keep coin1_raw=1 for 20 cycles -> no rs1, rs2 or coin_rej. Drop coin1_raw to 0 for 6 cycles, then a clean coin1 insertion -> exactly one rs1 pulse.
- DEB_CYCLES=4, accept_en=1, coin2_raw held high for 10 cycles after reset-idle -> rs2 high exactly one cycle, between E5 and E6. rs1 and coin_rej stay 0. total_value=2 with COIN_STATS_EN, otherwise 0.
- coin1_raw bouncing 1,0,1,1,0 then stable high -> one rs1 pulse, timed from the start of the stable run. A 2-cycle glitch alone -> no pulse.
- coin1_raw and coin2_raw both high for 8 cycles -> exactly one coin_rej pulse, no rs1 or rs2.
- accept_en=0 at the ACCEPT edge, coin1 inserted -> coin_rej pulse only, total_value unchanged.
- COIN_STATS_EN, CNT_W=4, eight rs2 coins -> total_value saturates at 15, not 0. Then assert rst mid-DEBOUNCE -> all outputs 0 immediately and no pulse after release.

Source files
------------

// File: rtl/coin_acceptor.sv
// Coin sensor front end: 2-flop sync, debounce FSM, single rs1/rs2/coin_rej pulse per coin.
// Optional accepted-value total is enabled by defining COIN_STATS_EN.
module coin_acceptor #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             coin1_raw,
    input  logic             coin2_raw,
    input  logic             accept_en,
    output logic             rs1,
    output logic             rs2,
    output logic             coin_rej,
    output logic [CNT_W-1:0] total_value
);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        ACCEPT,
        RELEASE
    } state_e;

    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] s;

    state_e     state_q;
    logic [1:0] sel_q;
    logic [7:0] deb_cnt_q;
    logic [7:0] rel_cnt_q;
    logic       rs1_q;
    logic       rs2_q;
    logic       rej_q;

    // Bit 0 carries the 1-unit sensor, bit 1 the 2-unit sensor.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {coin2_raw, coin1_raw};
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;

    // Reset lands in RELEASE so a coin held through reset must clear before it can count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RELEASE;
            sel_q     <= '0;
            deb_cnt_q <= '0;
            rel_cnt_q <= '0;
            rs1_q     <= 1'b0;
            rs2_q     <= 1'b0;
            rej_q     <= 1'b0;
        end else begin
            rs1_q <= 1'b0;
            rs2_q <= 1'b0;
            rej_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (s != 2'b00) begin
                        sel_q     <= s;
                        deb_cnt_q <= 8'd1;
                        state_q   <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (s == 2'b00) begin
                        deb_cnt_q <= '0;
                        state_q   <= IDLE;
                    end else if (s != sel_q) begin
                        sel_q     <= s;
                        deb_cnt_q <= 8'd1;
                    end else if (deb_cnt_q >= DEB_LAST) begin
                        deb_cnt_q <= '0;
                        state_q   <= ACCEPT;
                        if (accept_en && sel_q == 2'b01) begin
                            rs1_q <= 1'b1;
                        end else if (accept_en && sel_q == 2'b10) begin
                            rs2_q <= 1'b1;
                        end else begin
                            rej_q <= 1'b1;
                        end
                    end else begin
                        deb_cnt_q <= deb_cnt_q + 8'd1;
                    end
                end
                ACCEPT: begin
                    rel_cnt_q <= '0;
                    state_q   <= RELEASE;
                end
                RELEASE: begin
                    if (s != 2'b00) begin
                        rel_cnt_q <= '0;
                    end else if (rel_cnt_q >= DEB_LAST) begin
                        rel_cnt_q <= '0;
                        state_q   <= IDLE;
                    end else begin
                        rel_cnt_q <= rel_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= RELEASE;
                end
            endcase
        end
    end

    assign rs1      = rs1_q;
    assign rs2      = rs2_q;
    assign coin_rej = rej_q;

`ifdef COIN_STATS_EN
    localparam logic [CNT_W-1:0] TOTAL_MAX = '1;

    logic [CNT_W-1:0] total_q;
    logic [CNT_W+1:0] total_d;

    // {rs2,rs1} read as a number is exactly the credited value (2 or 1).
    always_comb begin
        total_d = {2'b00, total_q} + {{CNT_W{1'b0}}, rs2_q, rs1_q};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            total_q <= '0;
        end else if (total_d > {2'b00, TOTAL_MAX}) begin
            total_q <= TOTAL_MAX;
        end else begin
            total_q <= total_d[CNT_W-1:0];
        end
    end

    assign total_value = total_q;
`else
    assign total_value = '0;
`endif

    a_onehot_pulse : assert property (@(posedge clk) disable iff (!rst)
        $onehot0({rs1, rs2, coin_rej}));

    a_single_cycle_pulse : assert property (@(posedge clk) disable iff (!rst)
        (rs1 || rs2 || coin_rej) |=> !(rs1 || rs2 || coin_rej));

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: expected pulses queued at stimulus, checked on negedge.
module tb_coin_acceptor;

    localparam int DEB = 4;
    localparam int CW  = 4;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          coin1_raw = 1'b0;
    logic          coin2_raw = 1'b0;
    logic          accept_en = 1'b1;
    logic          rs1;
    logic          rs2;
    logic          coin_rej;
    logic [CW-1:0] total_value;

    int n_cmp     = 0;
    int n_bad     = 0;
    int cyc       = 0;
    int exp_total = 0;

    typedef struct {
        logic [2:0] kind;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    coin_acceptor #(
        .DEB_CYCLES(DEB),
        .CNT_W     (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .coin1_raw  (coin1_raw),
        .coin2_raw  (coin2_raw),
        .accept_en  (accept_en),
        .rs1        (rs1),
        .rs2        (rs2),
        .coin_rej   (coin_rej),
        .total_value(total_value)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [2:0] kind);
        exp_t e;
        e.kind = kind;
        e.cyc  = cyc + DEB + 2;
        sb.push_back(e);
    endtask

    task automatic insert(input logic c1, input logic c2, input int hold, input logic [2:0] kind);
        coin1_raw = c1;
        coin2_raw = c2;
        push_exp(kind);
        tick(hold);
        coin1_raw = 1'b0;
        coin2_raw = 1'b0;
        tick(2 * DEB + 4);
    endtask

    // Kind encoding: {coin_rej, rs2, rs1}.
    always @(negedge clk) begin
        logic [2:0] k;
        exp_t       e;
        if (rst && (rs1 || rs2 || coin_rej)) begin
            k = {coin_rej, rs2, rs1};
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 32'(k), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("pulse_kind", 32'(k), 32'(e.kind));
                chk("pulse_cycle", cyc, e.cyc);
`ifdef COIN_STATS_EN
                if (e.kind == 3'b001) exp_total = exp_total + 1;
                if (e.kind == 3'b010) exp_total = exp_total + 2;
                if (exp_total > (1 << CW) - 1) exp_total = (1 << CW) - 1;
`endif
            end
        end
    end

    initial begin
        logic [4:0] bounce;
        bounce = 5'b01101;

        rst       = 1'b0;
        coin1_raw = 1'b1;
        tick(3);
        chk("rst_rs1", 32'(rs1), 32'd0);
        chk("rst_rs2", 32'(rs2), 32'd0);
        chk("rst_rej", 32'(coin_rej), 32'd0);
        chk("rst_total", 32'(total_value), 32'd0);

        rst = 1'b1;
        tick(20);
        coin1_raw = 1'b0;
        tick(6);
        insert(1'b1, 1'b0, 10, 3'b001);
        chk("total_after_coin1", 32'(total_value), exp_total);

        insert(1'b0, 1'b1, 10, 3'b010);
        chk("total_after_coin2", 32'(total_value), exp_total);

        // Bounce 1,0,1,1,0 (LSB first) then stable high.
        for (int i = 0; i < 5; i++) begin
            coin1_raw = bounce[i];
            tick(1);
        end
        coin1_raw = 1'b1;
        push_exp(3'b001);
        tick(10);
        coin1_raw = 1'b0;
        tick(2 * DEB + 4);

        coin1_raw = 1'b1;
        tick(2);
        coin1_raw = 1'b0;
        tick(2 * DEB + 4);

        insert(1'b1, 1'b1, 8, 3'b100);

        accept_en = 1'b0;
        insert(1'b1, 1'b0, 10, 3'b100);
        accept_en = 1'b1;
        chk("total_after_refused", 32'(total_value), exp_total);

        coin1_raw = 1'b1;
        push_exp(3'b100);
        tick(5);
        accept_en = 1'b0;
        tick(5);
        accept_en = 1'b1;
        coin1_raw = 1'b0;
        tick(2 * DEB + 4);

        accept_en = 1'b0;
        coin2_raw = 1'b1;
        push_exp(3'b010);
        tick(5);
        accept_en = 1'b1;
        tick(5);
        coin2_raw = 1'b0;
        tick(2 * DEB + 4);

        for (int i = 0; i < 8; i++) begin
            insert(1'b0, 1'b1, 10, 3'b010);
        end
        chk("total_saturated", 32'(total_value), exp_total);

        coin1_raw = 1'b1;
        tick(4);
        rst = 1'b0;
        #1;
        exp_total = 0;
        chk("midrst_rs1", 32'(rs1), 32'd0);
        chk("midrst_rs2", 32'(rs2), 32'd0);
        chk("midrst_rej", 32'(coin_rej), 32'd0);
        chk("midrst_total", 32'(total_value), 32'd0);
        tick(3);
        rst = 1'b1;
        tick(20);
        coin1_raw = 1'b0;
        tick(2 * DEB + 4);
        chk("total_after_reset", 32'(total_value), 32'd0);

        insert(1'b1, 1'b0, 10, 3'b001);
        chk("total_final", 32'(total_value), exp_total);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
